// File: rtl/interrupt_request_sync.sv
// Interrupt request register: pin synchronisers, edge detection,
// freeze shadow latch and per-channel overrun flags.
module interrupt_request_sync #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] edge_level_config,
  input  logic               freeze,
  input  logic [NUM_IRQ-1:0] clear_interrupt_req,
  input  logic [NUM_IRQ-1:0] clear_overrun,
  input  logic [NUM_IRQ-1:0] interrupt_req_pin,
  output logic [NUM_IRQ-1:0] interrupt_req_register,
  output logic [NUM_IRQ-1:0] overrun,
  output logic               irq_pending
);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] shadow_q;
  logic [NUM_IRQ-1:0] sync_s;
  logic [NUM_IRQ-1:0] edge_det;
  logic [NUM_IRQ-1:0] irr_next;
  logic [NUM_IRQ-1:0] shadow_next;
  logic [NUM_IRQ-1:0] ovr_set;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_s & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= interrupt_req_pin;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  always_comb begin
    irr_next    = interrupt_req_register;
    shadow_next = shadow_q;
    ovr_set     = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (edge_level_config[i]) begin
        shadow_next[i] = 1'b0;
        if (clear_interrupt_req[i]) begin
          irr_next[i] = 1'b0;
        end else if (!freeze) begin
          irr_next[i] = sync_s[i];
        end
      end else begin
        // One request stored per channel; a further edge is an overrun
        ovr_set[i] = edge_det[i] & ~clear_interrupt_req[i]
                   & (interrupt_req_register[i] | shadow_q[i]);
        if (clear_interrupt_req[i] || freeze) begin
          shadow_next[i] = shadow_q[i] | edge_det[i];
          if (clear_interrupt_req[i]) begin
            irr_next[i] = 1'b0;
          end
        end else begin
          irr_next[i] = interrupt_req_register[i]
                      | edge_det[i] | shadow_q[i];
          shadow_next[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q                 <= '0;
      shadow_q               <= '0;
      interrupt_req_register <= '0;
      overrun                <= '0;
      irq_pending            <= 1'b0;
    end else begin
      prev_q                 <= sync_s;
      shadow_q               <= shadow_next;
      interrupt_req_register <= irr_next;
      overrun                <= ovr_set | (overrun & ~clear_overrun);
      irq_pending            <= |irr_next;
    end
  end

endmodule
